state_snapshot_monitor: RTL and testbench

- Synthesizable debug monitor for the SAT engine state list.
- Captures snapshots of the packed variable-state vector, the packed level-state vector and an 8-literal clause image.
- Exposes per-index decoded fields and summary counts, so the ctrl core and the bench can inspect engine state without software unpacking.
- Sits beside state_list and taps vars_states_o, lvl_states_o, var_value_o and learnt_lit_o.

---
 rtl/state_snapshot_monitor_pkg.sv | 36 +++
 rtl/state_snapshot_monitor_counter.sv | 25 ++
 rtl/state_snapshot_monitor.sv | 149 ++++++++++++++
 tb/tb_state_snapshot_monitor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_snapshot_monitor_pkg.sv
// Shared encodings and field offsets for the SAT state-list snapshot monitor.
package state_snapshot_monitor_pkg;

  localparam logic [1:0] VAL_UNASSIGNED = 2'b00;
  localparam logic [1:0] VAL_TRUE       = 2'b01;
  localparam logic [1:0] VAL_FALSE      = 2'b10;

  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_POS  = 2'b01;
  localparam logic [1:0] LIT_NEG  = 2'b10;

  // Variable state = {lvl, value[2:0]}; level state = {dcd_bin, has_bkt}.
  localparam int VAR_VALUE_LSB   = 0;
  localparam int VAR_VALUE_W     = 3;
  localparam int VAR_LVL_LSB     = 3;
  localparam int LVL_HAS_BKT_BIT = 0;
  localparam int LVL_BIN_LSB     = 1;

  function automatic logic is_assigned(input logic [2:0] value);
    return (value[1:0] == VAL_TRUE) || (value[1:0] == VAL_FALSE);
  endfunction

  function automatic logic is_lit(input logic [1:0] lit);
    return (lit == LIT_POS) || (lit == LIT_NEG);
  endfunction

  // A clause built from the current assignment blocks it: each literal opposes its value.
  function automatic logic [1:0] negate_value(input logic [2:0] value);
    case (value[1:0])
      VAL_TRUE:  return LIT_NEG;
      VAL_FALSE: return LIT_POS;
      default:   return LIT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/state_snapshot_monitor_counter.sv
// snapshot_counter: counts flagged entries and finds the largest key among them.
module snapshot_counter #(
  parameter int N         = 8,
  parameter int WIDTH_KEY = 16,
  parameter int WIDTH_CNT = 4
) (
  input  logic [N-1:0]           present,
  input  logic [N*WIDTH_KEY-1:0] keys,
  output logic [WIDTH_CNT-1:0]   count,
  output logic [WIDTH_KEY-1:0]   max_key
);

  always_comb begin
    count   = '0;
    max_key = '0;
    for (int i = 0; i < N; i++) begin
      if (present[i]) begin
        count = count + WIDTH_CNT'(1);
        if (keys[i*WIDTH_KEY +: WIDTH_KEY] > max_key)
          max_key = keys[i*WIDTH_KEY +: WIDTH_KEY];
      end
    end
  end

endmodule

// File: rtl/state_snapshot_monitor.sv
// Debug monitor: snapshots variable/level state vectors and a clause image, decodes by index.
module state_snapshot_monitor
  import state_snapshot_monitor_pkg::*;
#(
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_VAR_STATES = 3 + WIDTH_LVL,
  parameter int WIDTH_LVL_STATES = WIDTH_BIN_ID + 1,
  parameter int WIDTH_IDX        = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 vs_set_i,
  input  logic [NUM_VARS*WIDTH_VAR_STATES-1:0] vs_data_i,
  input  logic                                 ls_set_i,
  input  logic [NUM_LVLS*WIDTH_LVL_STATES-1:0] ls_data_i,
  input  logic                                 cd_reset_i,
  input  logic                                 cd_set_values_i,
  input  logic [NUM_VARS*3-1:0]                cd_values_i,
  input  logic                                 cd_set_clause_i,
  input  logic [NUM_VARS*2-1:0]                cd_lits_i,
  input  logic [WIDTH_IDX-1:0]                 sel_i,
  output logic [2:0]                           var_value_o,
  output logic [WIDTH_LVL-1:0]                 var_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]              lvl_dcd_bin_o,
  output logic                                 lvl_has_bkt_o,
  output logic [1:0]                           lit_o,
  output logic [WIDTH_IDX:0]                   num_assigned_o,
  output logic [WIDTH_LVL-1:0]                 max_var_lvl_o,
  output logic [WIDTH_IDX:0]                   num_lits_o,
  output logic                                 clause_empty_o,
  output logic                                 vs_valid_o,
  output logic                                 ls_valid_o
);

  logic [NUM_VARS*WIDTH_VAR_STATES-1:0] vs_q;
  logic [NUM_LVLS*WIDTH_LVL_STATES-1:0] ls_q;
  logic [NUM_VARS*2-1:0]                lits_q;
  logic [NUM_VARS*2-1:0]                lits_next;

  logic [NUM_VARS-1:0]           vs_present;
  logic [NUM_VARS*WIDTH_LVL-1:0] vs_lvls;
  logic [WIDTH_IDX:0]            vs_count;
  logic [WIDTH_LVL-1:0]          vs_max_lvl;
  logic [NUM_VARS-1:0]           lit_present;
  logic [WIDTH_IDX:0]            lit_count;
  logic                          lit_any;

  always_comb begin
    vs_present = '0;
    vs_lvls    = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      vs_present[i] = is_assigned(vs_data_i[i*WIDTH_VAR_STATES + VAR_VALUE_LSB +: VAR_VALUE_W]);
      vs_lvls[i*WIDTH_LVL +: WIDTH_LVL] = vs_data_i[i*WIDTH_VAR_STATES + VAR_LVL_LSB +: WIDTH_LVL];
    end
  end

  // Clause image next state; an idle cycle holds the current image.
  always_comb begin
    lits_next = lits_q;
    if (cd_reset_i) begin
      lits_next = '0;
    end else if (cd_set_clause_i) begin
      for (int i = 0; i < NUM_VARS; i++)
        lits_next[2*i +: 2] = is_lit(cd_lits_i[2*i +: 2]) ? cd_lits_i[2*i +: 2] : LIT_NONE;
    end else if (cd_set_values_i) begin
      for (int i = 0; i < NUM_VARS; i++)
        lits_next[2*i +: 2] = negate_value(cd_values_i[3*i +: 3]);
    end
  end

  always_comb begin
    lit_present = '0;
    for (int i = 0; i < NUM_VARS; i++)
      lit_present[i] = is_lit(lits_next[2*i +: 2]);
  end

  snapshot_counter #(
    .N(NUM_VARS), .WIDTH_KEY(WIDTH_LVL), .WIDTH_CNT(WIDTH_IDX + 1)
  ) u_vs_counter (
    .present (vs_present),
    .keys    (vs_lvls),
    .count   (vs_count),
    .max_key (vs_max_lvl)
  );

  // Keys equal to the flags make max_key an "any literal present" bit.
  snapshot_counter #(
    .N(NUM_VARS), .WIDTH_KEY(1), .WIDTH_CNT(WIDTH_IDX + 1)
  ) u_lit_counter (
    .present (lit_present),
    .keys    (lit_present),
    .count   (lit_count),
    .max_key (lit_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_q           <= '0;
      ls_q           <= '0;
      lits_q         <= '0;
      num_assigned_o <= '0;
      max_var_lvl_o  <= '0;
      num_lits_o     <= '0;
      clause_empty_o <= 1'b1;
      vs_valid_o     <= 1'b0;
      ls_valid_o     <= 1'b0;
    end else begin
      if (vs_set_i) begin
        vs_q           <= vs_data_i;
        num_assigned_o <= vs_count;
        max_var_lvl_o  <= vs_max_lvl;
        vs_valid_o     <= 1'b1;
      end
      if (ls_set_i) begin
        ls_q       <= ls_data_i;
        ls_valid_o <= 1'b1;
      end
      lits_q         <= lits_next;
      num_lits_o     <= lit_count;
      clause_empty_o <= !lit_any;
    end
  end

  // Index compare per slot: indices past NUM_VARS/NUM_LVLS match nothing and read 0.
  always_comb begin
    var_value_o   = '0;
    var_lvl_o     = '0;
    lit_o         = '0;
    lvl_dcd_bin_o = '0;
    lvl_has_bkt_o = 1'b0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (sel_i == WIDTH_IDX'(i)) begin
        var_value_o = vs_q[i*WIDTH_VAR_STATES + VAR_VALUE_LSB +: VAR_VALUE_W];
        var_lvl_o   = vs_q[i*WIDTH_VAR_STATES + VAR_LVL_LSB +: WIDTH_LVL];
        lit_o       = lits_q[2*i +: 2];
      end
    end
    for (int i = 0; i < NUM_LVLS; i++) begin
      if (sel_i == WIDTH_IDX'(i)) begin
        lvl_dcd_bin_o = ls_q[i*WIDTH_LVL_STATES + LVL_BIN_LSB +: WIDTH_BIN_ID];
        lvl_has_bkt_o = ls_q[i*WIDTH_LVL_STATES + LVL_HAS_BKT_BIT];
      end
    end
  end

endmodule

// File: tb/tb_state_snapshot_monitor.sv
// Bench for state_snapshot_monitor: directed scenarios plus random traffic vs a field-level model.
module tb_state_snapshot_monitor;

  localparam int NV  = 8;
  localparam int NL  = 8;
  localparam int WL  = 16;
  localparam int WB  = 10;
  localparam int WV  = 3 + WL;
  localparam int WLS = WB + 1;
  localparam int WI  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              vs_set_i = 1'b0;
  logic [NV*WV-1:0]  vs_data_i = '0;
  logic              ls_set_i = 1'b0;
  logic [NL*WLS-1:0] ls_data_i = '0;
  logic              cd_reset_i = 1'b0;
  logic              cd_set_values_i = 1'b0;
  logic [NV*3-1:0]   cd_values_i = '0;
  logic              cd_set_clause_i = 1'b0;
  logic [NV*2-1:0]   cd_lits_i = '0;
  logic [WI-1:0]     sel_i = '0;
  logic [2:0]        var_value_o;
  logic [WL-1:0]     var_lvl_o;
  logic [WB-1:0]     lvl_dcd_bin_o;
  logic              lvl_has_bkt_o;
  logic [1:0]        lit_o;
  logic [WI:0]       num_assigned_o;
  logic [WL-1:0]     max_var_lvl_o;
  logic [WI:0]       num_lits_o;
  logic              clause_empty_o;
  logic              vs_valid_o;
  logic              ls_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: decoded fields per slot.
  logic [2:0]    m_val[NV];
  logic [WL-1:0] m_lvl[NV];
  logic [WB-1:0] m_bin[NL];
  logic          m_bkt[NL];
  logic [1:0]    m_lit[NV];
  logic          m_vs_valid, m_ls_valid;
  int            m_nassigned;
  logic [WL-1:0] m_maxlvl;

  state_snapshot_monitor dut (
    .clk(clk), .rst(rst),
    .vs_set_i(vs_set_i), .vs_data_i(vs_data_i),
    .ls_set_i(ls_set_i), .ls_data_i(ls_data_i),
    .cd_reset_i(cd_reset_i), .cd_set_values_i(cd_set_values_i), .cd_values_i(cd_values_i),
    .cd_set_clause_i(cd_set_clause_i), .cd_lits_i(cd_lits_i),
    .sel_i(sel_i),
    .var_value_o(var_value_o), .var_lvl_o(var_lvl_o),
    .lvl_dcd_bin_o(lvl_dcd_bin_o), .lvl_has_bkt_o(lvl_has_bkt_o),
    .lit_o(lit_o), .num_assigned_o(num_assigned_o), .max_var_lvl_o(max_var_lvl_o),
    .num_lits_o(num_lits_o), .clause_empty_o(clause_empty_o),
    .vs_valid_o(vs_valid_o), .ls_valid_o(ls_valid_o)
  );

  always #5 clk = ~clk;

  function automatic int model_num_lits();
    int n = 0;
    for (int i = 0; i < NV; i++) if (m_lit[i] != 2'b00) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin m_val[i] = '0; m_lvl[i] = '0; m_lit[i] = '0; end
    for (int i = 0; i < NL; i++) begin m_bin[i] = '0; m_bkt[i] = 1'b0; end
    m_vs_valid = 1'b0; m_ls_valid = 1'b0; m_nassigned = 0; m_maxlvl = '0;
  endtask

  // Drives one clock edge with the given strobes, then updates the model by the rules.
  task automatic apply(input logic vs_set, input logic [NV*WV-1:0] vsd,
                       input logic ls_set, input logic [NL*WLS-1:0] lsd,
                       input logic cdr, input logic cdv, input logic [NV*3-1:0] vals,
                       input logic cdc, input logic [NV*2-1:0] lits);
    @(negedge clk);
    vs_set_i = vs_set; vs_data_i = vsd; ls_set_i = ls_set; ls_data_i = lsd;
    cd_reset_i = cdr; cd_set_values_i = cdv; cd_values_i = vals;
    cd_set_clause_i = cdc; cd_lits_i = lits;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      if (vs_set) begin
        m_vs_valid = 1'b1; m_nassigned = 0; m_maxlvl = '0;
        for (int i = 0; i < NV; i++) begin
          m_val[i] = vsd[i*WV +: 3];
          m_lvl[i] = vsd[i*WV+3 +: WL];
          if (m_val[i][1:0] == 2'b01 || m_val[i][1:0] == 2'b10) begin
            m_nassigned++;
            if (m_lvl[i] > m_maxlvl) m_maxlvl = m_lvl[i];
          end
        end
      end
      if (ls_set) begin
        m_ls_valid = 1'b1;
        for (int i = 0; i < NL; i++) begin
          m_bkt[i] = lsd[i*WLS];
          m_bin[i] = lsd[i*WLS+1 +: WB];
        end
      end
      if (cdr) begin
        for (int i = 0; i < NV; i++) m_lit[i] = 2'b00;
      end else if (cdc) begin
        for (int i = 0; i < NV; i++) m_lit[i] = (lits[2*i +: 2] == 2'b11) ? 2'b00 : lits[2*i +: 2];
      end else if (cdv) begin
        for (int i = 0; i < NV; i++)
          case (vals[3*i +: 2])
            2'b01:   m_lit[i] = 2'b10;
            2'b10:   m_lit[i] = 2'b01;
            default: m_lit[i] = 2'b00;
          endcase
      end
    end
    #1;
    vs_set_i = 1'b0; ls_set_i = 1'b0; cd_reset_i = 1'b0;
    cd_set_values_i = 1'b0; cd_set_clause_i = 1'b0;
  endtask

  task automatic idle();
    apply(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(); idle();
    sel_i = 0; #1;
    n_checks++; if ({var_value_o, var_lvl_o, lvl_dcd_bin_o, lvl_has_bkt_o, lit_o} !== '0) begin
      n_fail++; $display("FAIL reset_fields got %h required 0", {var_value_o, var_lvl_o, lvl_dcd_bin_o, lvl_has_bkt_o, lit_o}); end
    n_checks++; if ({num_assigned_o, max_var_lvl_o, num_lits_o} !== '0) begin
      n_fail++; $display("FAIL reset_counts got %h required 0", {num_assigned_o, max_var_lvl_o, num_lits_o}); end
    n_checks++; if ({clause_empty_o, vs_valid_o, ls_valid_o} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags got %b required 100", {clause_empty_o, vs_valid_o, ls_valid_o}); end
    rst = 1'b1;
    idle();
  endtask

  task automatic test_vs_capture();
    logic [NV*WV-1:0] d = '0;
    d[0*WV +: WV] = {16'd3, 3'b001};
    d[5*WV +: WV] = {16'd7, 3'b110};
    apply(1'b1, d, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    sel_i = 5; #1;
    n_checks++; if (num_assigned_o !== 4'd2) begin
      n_fail++; $display("FAIL vs_num_assigned got %0d required 2", num_assigned_o); end
    n_checks++; if (max_var_lvl_o !== 16'd7) begin
      n_fail++; $display("FAIL vs_max_lvl got %0d required 7", max_var_lvl_o); end
    n_checks++; if (var_value_o !== 3'b110 || var_lvl_o !== 16'd7) begin
      n_fail++; $display("FAIL vs_sel5 got %b/%0d required 110/7", var_value_o, var_lvl_o); end
    n_checks++; if (vs_valid_o !== 1'b1 || ls_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL vs_valid got %b%b required 10", vs_valid_o, ls_valid_o); end
  endtask

  task automatic test_ls_capture();
    logic [NL*WLS-1:0] d = '0;
    d[2*WLS +: WLS] = {10'd9, 1'b1};
    apply(1'b0, '0, 1'b1, d, 1'b0, 1'b0, '0, 1'b0, '0);
    sel_i = 2; #1;
    n_checks++; if (lvl_dcd_bin_o !== 10'd9 || lvl_has_bkt_o !== 1'b1) begin
      n_fail++; $display("FAIL ls_sel2 got %0d/%b required 9/1", lvl_dcd_bin_o, lvl_has_bkt_o); end
    n_checks++; if (ls_valid_o !== 1'b1 || num_assigned_o !== 4'd2) begin
      n_fail++; $display("FAIL ls_valid got %b/%0d required 1/2", ls_valid_o, num_assigned_o); end
  endtask

  task automatic test_cd_values();
    logic [NV*3-1:0] v = '0;
    v[1*3 +: 3] = 3'b001;
    v[4*3 +: 3] = 3'b010;
    apply(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, v, 1'b0, '0);
    sel_i = 1; #1;
    n_checks++; if (lit_o !== 2'b10) begin n_fail++; $display("FAIL cdv_lit1 got %b required 10", lit_o); end
    sel_i = 4; #1;
    n_checks++; if (lit_o !== 2'b01) begin n_fail++; $display("FAIL cdv_lit4 got %b required 01", lit_o); end
    n_checks++; if (num_lits_o !== 4'd2 || clause_empty_o !== 1'b0) begin
      n_fail++; $display("FAIL cdv_count got %0d/%b required 2/0", num_lits_o, clause_empty_o); end
  endtask

  task automatic test_cd_priority();
    apply(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 24'hffffff, 1'b1, 16'h5555);
    sel_i = 1; #1;
    n_checks++; if (num_lits_o !== 4'd0 || clause_empty_o !== 1'b1 || lit_o !== 2'b00) begin
      n_fail++; $display("FAIL cd_reset_prio got %0d/%b/%b required 0/1/00", num_lits_o, clause_empty_o, lit_o); end
    // Clause load must beat value build.
    apply(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 24'h249249, 1'b1, 16'h0002);
    sel_i = 0; #1;
    n_checks++; if (lit_o !== 2'b10 || num_lits_o !== 4'd1) begin
      n_fail++; $display("FAIL cd_clause_prio got %b/%0d required 10/1", lit_o, num_lits_o); end
  endtask

  task automatic test_cd_clause_normalize();
    logic [NV*2-1:0] l = '0;
    l[3*2 +: 2] = 2'b11;
    l[0*2 +: 2] = 2'b01;
    apply(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, l);
    sel_i = 3; #1;
    n_checks++; if (lit_o !== 2'b00) begin n_fail++; $display("FAIL cdc_norm3 got %b required 00", lit_o); end
    sel_i = 0; #1;
    n_checks++; if (lit_o !== 2'b01 || num_lits_o !== 4'd1) begin
      n_fail++; $display("FAIL cdc_lit0 got %b/%0d required 01/1", lit_o, num_lits_o); end
  endtask

  task automatic test_back_to_back();
    logic [NV*WV-1:0] d = '0;
    d[7*WV +: WV] = {16'hfffe, 3'b101};
    apply(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    apply(1'b1, d, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    sel_i = 7; #1;
    n_checks++; if (num_assigned_o !== 4'd1 || max_var_lvl_o !== 16'hfffe || var_value_o !== 3'b101) begin
      n_fail++; $display("FAIL b2b_vs got %0d/%h/%b required 1/fffe/101", num_assigned_o, max_var_lvl_o, var_value_o); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      logic [NV*WV-1:0]  vsd;
      logic [NL*WLS-1:0] lsd;
      logic [NV*3-1:0]   vals;
      logic [NV*2-1:0]   lits;
      for (int i = 0; i < NV; i++) begin
        vsd[i*WV +: WV] = {16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7))};
        vals[i*3 +: 3]  = 3'($urandom_range(0, 7));
        lits[i*2 +: 2]  = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < NL; i++) lsd[i*WLS +: WLS] = 11'($urandom_range(0, 2047));
      apply(1'($urandom_range(0, 1)), vsd, 1'($urandom_range(0, 1)), lsd,
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), vals,
            1'($urandom_range(0, 1)), lits);
      n_checks++; if (num_assigned_o !== 4'(m_nassigned) || max_var_lvl_o !== m_maxlvl) begin
        n_fail++; $display("FAIL rnd_vs_sum it=%0d got %0d/%h required %0d/%h", it, num_assigned_o, max_var_lvl_o, m_nassigned, m_maxlvl); end
      n_checks++; if (num_lits_o !== 4'(model_num_lits()) || clause_empty_o !== (model_num_lits() == 0)) begin
        n_fail++; $display("FAIL rnd_lit_sum it=%0d got %0d/%b required %0d", it, num_lits_o, clause_empty_o, model_num_lits()); end
      n_checks++; if (vs_valid_o !== m_vs_valid || ls_valid_o !== m_ls_valid) begin
        n_fail++; $display("FAIL rnd_valid it=%0d got %b%b required %b%b", it, vs_valid_o, ls_valid_o, m_vs_valid, m_ls_valid); end
      for (int s = 0; s < NV; s++) begin
        sel_i = WI'(s); #1;
        n_checks++; if (var_value_o !== m_val[s] || var_lvl_o !== m_lvl[s] || lit_o !== m_lit[s]) begin
          n_fail++; $display("FAIL rnd_var it=%0d sel=%0d got %b/%h/%b required %b/%h/%b", it, s,
                             var_value_o, var_lvl_o, lit_o, m_val[s], m_lvl[s], m_lit[s]); end
        n_checks++; if (lvl_dcd_bin_o !== m_bin[s] || lvl_has_bkt_o !== m_bkt[s]) begin
          n_fail++; $display("FAIL rnd_lvl it=%0d sel=%0d got %h/%b required %h/%b", it, s,
                             lvl_dcd_bin_o, lvl_has_bkt_o, m_bin[s], m_bkt[s]); end
      end
    end
  endtask

  task automatic test_reset_override();
    logic [NV*WV-1:0] d = '0;
    d[0*WV +: WV] = {16'd3, 3'b001};
    rst = 1'b0;
    apply(1'b1, d, 1'b1, '1, 1'b0, 1'b0, '0, 1'b1, 16'h5555);
    rst = 1'b1;
    idle();
    sel_i = 0; #1;
    n_checks++; if (vs_valid_o !== 1'b0 || ls_valid_o !== 1'b0 || num_assigned_o !== '0) begin
      n_fail++; $display("FAIL rst_override_valid got %b%b/%0d required 00/0", vs_valid_o, ls_valid_o, num_assigned_o); end
    n_checks++; if (var_value_o !== 3'b000 || var_lvl_o !== '0 || clause_empty_o !== 1'b1 || lit_o !== 2'b00) begin
      n_fail++; $display("FAIL rst_override_data got %b/%0d/%b/%b required 000/0/1/00", var_value_o, var_lvl_o, clause_empty_o, lit_o); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_vs_capture();
    test_ls_capture();
    test_cd_values();
    test_cd_priority();
    test_cd_clause_normalize();
    test_back_to_back();
    test_random();
    test_reset_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
